// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MemOp codes, FSM states, request record.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

    localparam int XLEN  = 32;
    // Holds LATENCY (max 15) plus the optional random extra (max 3).
    localparam int CNT_W = 5;

    // MemOp encodings. The request port carries raw 3-bit codes, including
    // unsupported ones, so these are plain constants rather than an enum.
    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            wen;
        logic [2:0]      op;
        logic [XLEN-1:0] wdata;
    } req_t;

    // Loads accept b/h/w/bu/hu; stores only b/h/w.
    function automatic logic op_supported(input logic wen, input logic [2:0] op);
        logic ok;
        case (op)
            MOP_B, MOP_H, MOP_W: ok = 1'b1;
            MOP_BU, MOP_HU:      ok = ~wen;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load extract/extend, store byte-enable + merge, misalignment detect.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
// Ports: rd_word/lane/op/wdata in; load_data, byte_en, merged_word, misaligned out.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [XLEN-1:0] rd_word,
    input  logic [1:0]      lane,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [3:0]      byte_en,
    output logic [XLEN-1:0] merged_word,
    output logic            misaligned
);

    logic [XLEN-1:0] rd_shift;
    logic [XLEN-1:0] wd_shift;

    always_comb begin
        rd_shift = rd_word >> {lane, 3'b000};
        // Shifting by the full lane works for halfwords too: a misaligned
        // halfword never writes, so only lane 0 or 2 matter.
        wd_shift = wdata << {lane, 3'b000};

        load_data = '0;
        byte_en   = 4'b0000;
        case (op)
            MOP_B:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            MOP_BU: load_data = {24'h0, rd_shift[7:0]};
            MOP_H:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            MOP_HU: load_data = {16'h0, rd_shift[15:0]};
            MOP_W:  load_data = rd_word;
            default: load_data = '0;
        endcase

        case (op)
            MOP_B:   byte_en = 4'b0001 << lane;
            MOP_H:   byte_en = 4'b0011 << {lane[1], 1'b0};
            MOP_W:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase

        for (int b = 0; b < 4; b++) begin
            merged_word[8*b +: 8] = byte_en[b] ? wd_shift[8*b +: 8] : rd_word[8*b +: 8];
        end

        case (op[1:0])
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, held LATENCY cycles, then answered from word storage.
// Latency: resp_valid first high LATENCY+2 cycles after the handshake cycle; throughput 1 per LATENCY+3.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
// Ports: clk, rst (async, active-low); req_valid/req_ready/req_addr/req_wen/req_op/req_wdata;
//        resp_valid/resp_ready/resp_rdata/resp_err.
// Option macro DMEM_RAND_LATENCY_EN: adds lfsr[1:0] (16-bit LFSR, seed 16'hACE1) to each request's latency.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XLEN-1:0]  req_addr,
    input  logic             req_wen,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_rdata,
    output logic             resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  lat_load;
    req_t              req_q;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;
    logic [XLEN-1:0]   mem [DEPTH_WORDS];

    logic              accept;
    logic              exec;
    logic [29:0]       word_off;
    logic [IDX_W-1:0]  idx;
    logic              out_of_range;
    logic              fault;
    logic [XLEN-1:0]   rd_word;
    logic [XLEN-1:0]   load_data;
    logic [3:0]        byte_en;
    logic [XLEN-1:0]   merged_word;
    logic              misaligned;

    // Gated by rst so the port reads 0 while reset is held even though the
    // state register already sits in IDLE.
    assign req_ready  = rst & (state_q == S_IDLE);
    assign accept     = req_valid & req_ready;
    assign exec       = (state_q == S_WAIT) && (cnt_q == '0);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

`ifdef DMEM_RAND_LATENCY_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lat_load = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= 16'hACE1;
        end else if (accept) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end
`else
    assign lat_load = CNT_W'(LATENCY);
`endif

    // Address decode on the captured request. The unsigned subtraction wraps
    // for addresses below the base, so that case is checked explicitly.
    assign word_off     = 30'((req_q.addr - ADDR_BASE) >> 2);
    assign idx          = word_off[IDX_W-1:0];
    assign out_of_range = (req_q.addr < ADDR_BASE) || ({2'b00, word_off} >= 32'(DEPTH_WORDS));
    assign rd_word      = mem[idx];
    assign fault        = out_of_range | misaligned | ~op_supported(req_q.wen, req_q.op);

    dmem_lane_align u_lane_align (
        .rd_word     (rd_word),
        .lane        (req_q.addr[1:0]),
        .op          (req_q.op),
        .wdata       (req_q.wdata),
        .load_data   (load_data),
        .byte_en     (byte_en),
        .merged_word (merged_word),
        .misaligned  (misaligned)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q <= '{addr: req_addr, wen: req_wen, op: req_op, wdata: req_wdata};
                cnt_q <= lat_load;
            end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (exec) begin
                rdata_q <= (fault || req_q.wen) ? '0 : load_data;
                err_q   <= fault;
            end
        end
    end

    // Storage is not reset. A reset mid-transaction forces state to IDLE
    // asynchronously, so exec is low and an aborted store never lands.
    always_ff @(posedge clk) begin
        if (exec && req_q.wen && !fault) begin
            mem[idx] <= merged_word;
        end
    end

endmodule
